// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, latency
// limits and byte-to-word address helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned CNT_BITS    = 4;

    function automatic bit latency_ok(input int unsigned lat);
        return lat <= LATENCY_MAX;
    endfunction

    // Drops the byte offset; the caller truncates to its own index width.
    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage to data-memory request/response bundle.
interface dmem_responder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             req_valid;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [31:0]      resp_rdata;
    logic             mem_stall;
    logic             busy;
    logic [CNT_W-1:0] stat_req;
    logic [CNT_W-1:0] stat_stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  resp_rdata, mem_stall, busy, stat_req, stat_stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output resp_rdata, mem_stall, busy, stat_req, stat_stall
    );
endinterface

// File: rtl/dmem_array.sv
// Word-wide storage: synchronous write, asynchronous read, whole-array
// clear on reset.
module dmem_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: stalls the MEM stage for LATENCY
// cycles per request, then completes the load/store and updates statistics.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  mem_if
);

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("dmem_responder: LATENCY out of range 0..15");
    end

    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;
    logic              wr_en;
    logic [CNT_W-1:0]  stat_req_q;
    logic [CNT_W-1:0]  stat_stall_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign idx = ADDR_W'(word_index(mem_if.req_addr));

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en),
        .addr_i  (idx),
        .wdata_i (mem_if.req_wdata),
        .rdata_o (rd_word)
    );

    assign mem_if.stat_req   = stat_req_q;
    assign mem_if.stat_stall = stat_stall_q;

    if (LATENCY == 0) begin : g_lat0
        // Single-cycle memory: read straight through, write at the edge.
        assign wr_en             = mem_if.req_valid & mem_if.req_we;
        assign mem_if.resp_rdata = rd_word;
        assign mem_if.mem_stall  = 1'b0;
        assign mem_if.busy       = 1'b0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stat_req_q   <= '0;
                stat_stall_q <= '0;
            end else begin
                stat_stall_q <= '0;
                if (mem_if.req_valid) begin
                    stat_req_q <= sat_inc(stat_req_q);
                end
            end
        end
    end else begin : g_fsm
        // The IDLE cycle is the first stall cycle, so WAIT covers LATENCY-1.
        localparam bit FAST = (LATENCY == 1);
        localparam logic [CNT_BITS-1:0] CNT_INIT =
            (LATENCY >= 2) ? CNT_BITS'(LATENCY - 2) : '0;

        state_e              state_q;
        logic [CNT_BITS-1:0] cnt_q;
        logic [31:0]         rdata_q;
        logic                access;

        assign access = mem_if.req_valid &
                        (((state_q == ST_IDLE) && FAST) ||
                         ((state_q == ST_WAIT) && (cnt_q == '0)));
        assign wr_en  = access & mem_if.req_we;

        assign mem_if.mem_stall  = mem_if.req_valid & (state_q != ST_DONE) & ~rst;
        assign mem_if.busy       = (state_q != ST_IDLE);
        assign mem_if.resp_rdata = rdata_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q      <= ST_IDLE;
                cnt_q        <= '0;
                rdata_q      <= '0;
                stat_req_q   <= '0;
                stat_stall_q <= '0;
            end else begin
                if (mem_if.mem_stall) begin
                    stat_stall_q <= sat_inc(stat_stall_q);
                end
                if (access && !mem_if.req_we) begin
                    rdata_q <= rd_word;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (mem_if.req_valid) begin
                            if (FAST) begin
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_WAIT;
                                cnt_q   <= CNT_INIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        // A dropped request aborts without touching memory.
                        if (!mem_if.req_valid) begin
                            state_q <= ST_IDLE;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_BITS'(1);
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state_q    <= ST_IDLE;
                        stat_req_q <= sat_inc(stat_req_q);
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
